// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM->WB bus and write-back result signals grouped for wb_stage
interface wb_stage_if;
    logic         WB_valid;
    logic [159:0] MEM_WB_bus_r;
    logic         WB_over;
    logic [3:0]   rf_wen;
    logic [4:0]   rf_wdest;
    logic [31:0]  rf_wdata;
    logic [4:0]   WB_wdest;
    logic         WB_hi_write;
    logic         WB_lo_write;
    logic [31:0]  WB_hi_data;
    logic [31:0]  WB_lo_data;
    logic [31:0]  HI_data;
    logic [31:0]  LO_data;
    logic [31:0]  cp0r_status;
    logic [31:0]  cp0r_cause;
    logic [31:0]  cp0r_epc;
    logic [31:0]  cp0r_badvaddr;
    logic         cancel;
    logic [31:0]  exc_pc;

    modport master (
        output WB_valid, MEM_WB_bus_r,
        input  WB_over, rf_wen, rf_wdest, rf_wdata, WB_wdest,
        input  WB_hi_write, WB_lo_write, WB_hi_data, WB_lo_data, HI_data, LO_data,
        input  cp0r_status, cp0r_cause, cp0r_epc, cp0r_badvaddr, cancel, exc_pc
    );

    modport slave (
        input  WB_valid, MEM_WB_bus_r,
        output WB_over, rf_wen, rf_wdest, rf_wdata, WB_wdest,
        output WB_hi_write, WB_lo_write, WB_hi_data, WB_lo_data, HI_data, LO_data,
        output cp0r_status, cp0r_cause, cp0r_epc, cp0r_badvaddr, cancel, exc_pc
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: GPR commit, HI/LO, CP0 and precise exception/eret redirect
module wb_stage #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST  = 32'h0040_0000,
    parameter logic [31:0] STATUS_WMSK = 32'h0000_FF03
) (
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   bus
);
    // CP0 address is {reg[4:0], sel[2:0]}
    localparam logic [7:0] CP0_BADVADDR = 8'd64;
    localparam logic [7:0] CP0_STATUS   = 8'd96;
    localparam logic [7:0] CP0_CAUSE    = 8'd104;
    localparam logic [7:0] CP0_EPC      = 8'd112;

    logic        w_jbr, w_wen, w_hi_wr, w_lo_wr, w_mfhi, w_mflo, w_mtc0, w_mfc0;
    logic        w_syscall, w_brk, w_ov, w_adel, w_ades, w_ri, w_eret;
    logic [4:0]  w_wdest;
    logic [7:0]  w_cp0_addr;
    logic [31:0] w_mem_res, w_lo_res, w_exe_res, w_pc;
    logic [3:0]  w_wbytes;

    assign {w_jbr, w_wen, w_wdest, w_mem_res, w_lo_res, w_hi_wr, w_lo_wr, w_mfhi, w_mflo,
            w_mtc0, w_mfc0, w_cp0_addr, w_syscall, w_brk, w_ov, w_adel, w_ades, w_ri, w_eret,
            w_exe_res, w_pc, w_wbytes} = bus.MEM_WB_bus_r;

    logic [31:0] r_hi, r_lo;
    logic [31:0] r_status, r_cause, r_epc, r_badvaddr;
    logic        r_prev_jbr;

    // Reset suppresses every side effect, including the redirect, even mid-flush
    logic w_live, w_exc_src, w_exc, w_commit, w_eret_go, w_mtc0_go, w_bd;
    assign w_live    = bus.WB_valid & ~reset;
    assign w_exc_src = w_ri | w_ov | w_syscall | w_brk | w_adel | w_ades;
    assign w_exc     = w_live & w_exc_src;
    assign w_commit  = w_live & ~w_exc_src;
    assign w_eret_go = w_commit & w_eret;
    assign w_mtc0_go = w_commit & w_mtc0 & ~w_eret;
    assign w_bd      = r_prev_jbr;

    logic [4:0] w_excode;
    always_comb begin
        w_excode = 5'd0;
        if (w_ri)           w_excode = 5'd10;
        else if (w_ov)      w_excode = 5'd12;
        else if (w_syscall) w_excode = 5'd8;
        else if (w_brk)     w_excode = 5'd9;
        else if (w_adel)    w_excode = 5'd4;
        else if (w_ades)    w_excode = 5'd5;
    end

    logic [31:0] w_cp0_rdata;
    always_comb begin
        w_cp0_rdata = 32'd0;
        case (w_cp0_addr)
            CP0_STATUS:   w_cp0_rdata = r_status;
            CP0_CAUSE:    w_cp0_rdata = r_cause;
            CP0_EPC:      w_cp0_rdata = r_epc;
            CP0_BADVADDR: w_cp0_rdata = r_badvaddr;
            default:      w_cp0_rdata = 32'd0;
        endcase
    end

    logic [31:0] w_rf_wdata;
    always_comb begin
        w_rf_wdata = w_mem_res;
        if (w_mfhi)      w_rf_wdata = r_hi;
        else if (w_mflo) w_rf_wdata = r_lo;
        else if (w_mfc0) w_rf_wdata = w_cp0_rdata;
    end

    assign bus.WB_over       = bus.WB_valid;
    assign bus.rf_wen        = w_commit ? ({4{w_wen}} & w_wbytes) : 4'd0;
    assign bus.rf_wdest      = w_wdest;
    assign bus.rf_wdata      = w_rf_wdata;
    assign bus.WB_wdest      = bus.WB_valid ? w_wdest : 5'd0;
    assign bus.WB_hi_write   = w_commit & w_hi_wr;
    assign bus.WB_lo_write   = w_commit & w_lo_wr;
    assign bus.WB_hi_data    = w_mem_res;
    assign bus.WB_lo_data    = w_lo_res;
    assign bus.HI_data       = r_hi;
    assign bus.LO_data       = r_lo;
    assign bus.cp0r_status   = r_status;
    assign bus.cp0r_cause    = r_cause;
    assign bus.cp0r_epc      = r_epc;
    assign bus.cp0r_badvaddr = r_badvaddr;
    assign bus.cancel        = w_exc | w_eret_go;
    assign bus.exc_pc        = w_exc ? EXC_VECTOR : r_epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_status   <= STATUS_RST;
            r_cause    <= 32'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_prev_jbr <= 1'b0;
        end else if (w_exc) begin
            r_cause    <= {w_bd, r_cause[30:7], w_excode, r_cause[1:0]};
            r_epc      <= w_bd ? (w_pc - 32'd4) : w_pc;
            r_status   <= {r_status[31:2], 1'b1, r_status[0]};
            r_prev_jbr <= 1'b0;
            if (w_adel | w_ades)
                r_badvaddr <= w_exe_res;
        end else if (w_commit) begin
            if (w_hi_wr) r_hi <= w_mem_res;
            if (w_lo_wr) r_lo <= w_lo_res;
            // eret leaves the delay-slot tracker clean for the handler's return target
            r_prev_jbr <= w_eret ? 1'b0 : w_jbr;
            if (w_eret_go) begin
                r_status <= {r_status[31:2], 1'b0, r_status[0]};
            end else if (w_mtc0_go) begin
                case (w_cp0_addr)
                    CP0_STATUS: r_status <= (r_status & ~STATUS_WMSK) | (w_mem_res & STATUS_WMSK);
                    CP0_CAUSE:  r_cause  <= {r_cause[31:10], w_mem_res[9:8], r_cause[7:0]};
                    CP0_EPC:    r_epc    <= w_mem_res;
                    default:    ;
                endcase
            end
        end
    end
endmodule
